rotate_controller: RTL and testbench

- FSM that sequences rotate_datapath: one start pulse processes all 64 lines × 25 bit positions through the file reader, the two counters and the file writer.
- Drives every datapath control input.
- Consumes the counter carry-outs co_c64 and co_c25.
- Exposes a ready/done handshake to the top-level encoder sequencer.

---
 rtl/rotate_controller_pkg.sv | 20 ++
 rtl/rotate_controller.sv | 176 +++++++++++++++++
 tb/tb_rotate_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rotate_controller_pkg.sv
// Shared definitions for the rotate controller: state encoding and the
// geometry of one rotate pass (lines x bit positions).
package rotate_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_LD_CURR = 3'd2,
    S_LD_DES  = 3'd3,
    S_WAIT    = 3'd4,
    S_BIT     = 3'd5,
    S_LINE    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam int ROT_LINES = 64;
  localparam int ROT_BITS  = 25;
  localparam int WAIT_W    = 4;

endpackage

// File: rtl/rotate_controller.sv
// Sequencer for rotate_datapath: one start pulse walks all lines, loading the
// file reader, streaming every bit position into the file writer, and stepping
// the line and index counters. Outputs are registered and decoded from the
// state being entered, so none of them depends combinationally on start.
// Optional macro ROTATE_CTRL_PERF_EN adds a saturating cycle counter output.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | ready for a request, ready=1
// S_INIT    | clear both counters, pulse dp_start
// S_LD_CURR | load current line into the file reader
// S_LD_DES  | load destination line into the file reader
// S_WAIT    | LD_WAIT idle cycles covering the file-read latency
// S_BIT     | stream one bit per cycle until the index counter carries
// S_LINE    | advance line counter, clear index counter
// S_DONE    | one-cycle completion pulse
module rotate_controller
  import rotate_pkg::*;
#(
  parameter int LD_WAIT = 0,
  parameter int PERF_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic co_c64,
  input  logic co_c25,
  output logic ld_curr_fr,
  output logic ld_des_fr,
  output logic en_fw,
  output logic init0_c64,
  output logic init0_c25,
  output logic en_c64,
  output logic en_c25,
  output logic dp_start,
  output logic ready,
  output logic done
`ifdef ROTATE_CTRL_PERF_EN
  ,output logic [PERF_W-1:0] cycle_cnt
`endif
);

  // Wait counter load value; the counter counts down to zero inclusive.
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (LD_WAIT > 0) ? WAIT_W'(LD_WAIT - 1) : '0;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic r_ld_curr, r_ld_des, r_en_fw, r_init0_c64, r_init0_c25;
  logic r_en_c64, r_en_c25, r_dp_start, r_ready, r_done;

  // Next-state logic and registered Moore outputs for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_ld_curr   <= 1'b0;
      r_ld_des    <= 1'b0;
      r_en_fw     <= 1'b0;
      r_init0_c64 <= 1'b0;
      r_init0_c25 <= 1'b0;
      r_en_c64    <= 1'b0;
      r_en_c25    <= 1'b0;
      r_dp_start  <= 1'b0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_ld_curr   <= 1'b0;
      r_ld_des    <= 1'b0;
      r_en_fw     <= 1'b0;
      r_init0_c64 <= 1'b0;
      r_init0_c25 <= 1'b0;
      r_en_c64    <= 1'b0;
      r_en_c25    <= 1'b0;
      r_dp_start  <= 1'b0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_INIT;
            r_init0_c64 <= 1'b1;
            r_init0_c25 <= 1'b1;
            r_dp_start  <= 1'b1;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_INIT: begin
          r_state   <= S_LD_CURR;
          r_ld_curr <= 1'b1;
        end
        S_LD_CURR: begin
          r_state  <= S_LD_DES;
          r_ld_des <= 1'b1;
        end
        S_LD_DES: begin
          if (LD_WAIT > 0) begin
            r_state <= S_WAIT;
            r_wait  <= WAIT_LOAD;
          end else begin
            r_state  <= S_BIT;
            r_en_fw  <= 1'b1;
            r_en_c25 <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_state  <= S_BIT;
            r_en_fw  <= 1'b1;
            r_en_c25 <= 1'b1;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_BIT: begin
          if (co_c25) begin
            r_state     <= S_LINE;
            r_en_c64    <= 1'b1;
            r_init0_c25 <= 1'b1;
          end else begin
            r_en_fw  <= 1'b1;
            r_en_c25 <= 1'b1;
          end
        end
        S_LINE: begin
          if (co_c64) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_LD_CURR;
            r_ld_curr <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ld_curr_fr = r_ld_curr;
  assign ld_des_fr  = r_ld_des;
  assign en_fw      = r_en_fw;
  assign init0_c64  = r_init0_c64;
  assign init0_c25  = r_init0_c25;
  assign en_c64     = r_en_c64;
  assign en_c25     = r_en_c25;
  assign dp_start   = r_dp_start;
  assign ready      = r_ready;
  assign done       = r_done;

`ifdef ROTATE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_cycle_cnt;

  // Count busy cycles of the current run; cleared on an accepted start so the
  // last run's total stays visible while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_cycle_cnt <= '0;
    end else if (r_cycle_cnt != '1) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_rotate_controller.sv
// Self-checking bench for rotate_controller. Two instances (LD_WAIT=0 and 3)
// share clock, reset and start; each is compared every cycle against an
// expected-output schedule computed arithmetically from the run offset.
module tb_rotate_controller;
  import rotate_pkg::*;

  localparam int PERF_W = 16;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] rdy;
  logic [1:0] busy;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Expected outputs at cycle offset k of a run (k=1 is the init cycle).
  // Bit order: ready, done, dp_start, ld_curr, ld_des, en_fw,
  //            init0_c64, init0_c25, en_c64, en_c25
  function automatic logic [9:0] exp_vec(input bit b, input int k, input int w);
    int per, t, j;
    logic [9:0] v;
    v   = '0;
    per = ROT_BITS + 3 + w;
    t   = 2 + ROT_LINES * per;
    if (!b) v[9] = 1'b1;
    else if (k == 1) begin
      v[7] = 1'b1; v[3] = 1'b1; v[2] = 1'b1;
    end else if (k == t) v[8] = 1'b1;
    else begin
      j = (k - 2) % per;
      if (j == 0) v[6] = 1'b1;
      else if (j == 1) v[5] = 1'b1;
      else if (j >= 2 + w && j < 2 + w + ROT_BITS) begin
        v[4] = 1'b1; v[0] = 1'b1;
      end else if (j == ROT_BITS + 2 + w) begin
        v[1] = 1'b1; v[2] = 1'b1;
      end
    end
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = 3 * g;
    localparam int T = 2 + ROT_LINES * (ROT_BITS + 3 + W);

    logic ld_curr_fr, ld_des_fr, en_fw, init0_c64, init0_c25;
    logic en_c64, en_c25, dp_start, ready, done, co_c25, co_c64;
    logic [9:0] obs, expv;
    int c25 = 0, c64 = 0, k = 0, last = 0;
    int n_ldc = 0, n_ldd = 0, n_fw = 0;
    bit mb = 1'b0, n25 = 1'b0, n64 = 1'b0;
`ifdef ROTATE_CTRL_PERF_EN
    logic [PERF_W-1:0] cyc;
`endif

    rotate_controller #(.LD_WAIT(W), .PERF_W(PERF_W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .co_c64    (co_c64),
      .co_c25    (co_c25),
      .ld_curr_fr(ld_curr_fr),
      .ld_des_fr (ld_des_fr),
      .en_fw     (en_fw),
      .init0_c64 (init0_c64),
      .init0_c25 (init0_c25),
      .en_c64    (en_c64),
      .en_c25    (en_c25),
      .dp_start  (dp_start),
      .ready     (ready),
      .done      (done)
`ifdef ROTATE_CTRL_PERF_EN
      ,.cycle_cnt(cyc)
`endif
    );

    assign obs  = {ready, done, dp_start, ld_curr_fr, ld_des_fr, en_fw,
                   init0_c64, init0_c25, en_c64, en_c25};
    assign expv = exp_vec(mb, k, W);
    // Carry-outs from the counter models, plus noise outside the states that use them.
    assign co_c25 = (c25 == ROT_BITS - 1)  | (n25 & ~expv[4]);
    assign co_c64 = (c64 == ROT_LINES - 1) | (n64 & ~expv[1]);
    assign rdy[g]  = ready;
    assign busy[g] = mb;

    // Behavioural datapath counters.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        c25 <= 0; c64 <= 0;
      end else begin
        if (init0_c25) c25 <= 0;
        else if (en_c25) c25 <= (c25 + 1) % ROT_BITS;
        if (init0_c64) c64 <= 0;
        else if (en_c64) c64 <= (c64 + 1) % ROT_LINES;
      end
    end

    // Run model: busy flag and cycle offset within the run.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        mb <= 1'b0; k <= 0; last <= 0;
      end else if (!mb) begin
        if (start) begin mb <= 1'b1; k <= 1; end
      end else if (k == T) begin
        mb <= 1'b0; k <= 0; last <= T;
      end else k <= k + 1;
    end

    always @(negedge clk) begin
      check($sformatf("outs_w%0d", W), 32'(obs), 32'(expv));
      check($sformatf("excl_w%0d", W),
            32'($countones({ld_curr_fr, ld_des_fr, en_fw}) <= 1), 32'd1);
`ifdef ROTATE_CTRL_PERF_EN
      check($sformatf("cycle_cnt_w%0d", W), 32'(cyc), mb ? 32'(k - 1) : 32'(last));
`endif
      n25 <= ($urandom_range(0, 3) == 0);
      n64 <= ($urandom_range(0, 3) == 0);
      if (mb && k == 1) begin
        n_ldc <= 0; n_ldd <= 0; n_fw <= 0;
      end else begin
        n_ldc <= n_ldc + int'(ld_curr_fr);
        n_ldd <= n_ldd + int'(ld_des_fr);
        n_fw  <= n_fw + int'(en_fw);
      end
      if (mb && k == T) begin
        check($sformatf("n_ld_curr_w%0d", W), 32'(n_ldc), 32'(ROT_LINES));
        check($sformatf("n_ld_des_w%0d", W), 32'(n_ldd), 32'(ROT_LINES));
        check($sformatf("n_en_fw_w%0d", W), 32'(n_fw), 32'(ROT_LINES * ROT_BITS));
      end
    end

    // Reset must act without waiting for a clock edge.
    always @(negedge rst) begin
      #1;
      check($sformatf("async_rst_w%0d", W), 32'(obs), 32'h200);
`ifdef ROTATE_CTRL_PERF_EN
      check($sformatf("async_rst_cyc_w%0d", W), 32'(cyc), 32'd0);
`endif
    end
  end

  task automatic wait_idle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (&rdy && !(|busy)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(rdy), 32'd3);

    // Single run with an ignored start at offset ~500 and random spurious starts.
    pulse_start();
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      if (&rdy && !(|busy)) break;
      if (i == 498) start = 1'b1;
      else if (rdy == 2'b00 && $urandom_range(0, 63) == 0) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    wait_idle("run1_idle", 50);
    repeat (20 + $urandom_range(0, 10)) @(negedge clk);
    check("no_requeue", 32'(rdy), 32'd3);

    // Asynchronous reset in the middle of the bit loop.
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_midrun_rst", 32'(rdy), 32'd3);

    // start held high: back-to-back runs.
    start = 1'b1;
    repeat (4000) @(negedge clk);
    start = 1'b0;
    wait_idle("held_idle", 2500);

    // Final run after a random gap; perf counter must clear and re-total.
    repeat ($urandom_range(1, 15)) @(negedge clk);
    pulse_start();
    wait_idle("run_last_idle", 2500);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
